// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game sequencer.
// Phase encodings match the phase output port directly.
package whack_pkg;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'b00,
    PH_COUNTDOWN = 2'b01,
    PH_PLAY      = 2'b10,
    PH_OVER      = 2'b11
  } phase_t;

  localparam int unsigned DEF_N_MOLES = 5;
  localparam int unsigned DEF_SCORE_W = 16;
  localparam int unsigned DEF_LFSR_W  = 16;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // Right-shifting Galois feedback masks; maximal-length for the tabulated widths.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      5:       return 32'h0000_0012;
      6:       return 32'h0000_0021;
      7:       return 32'h0000_0041;
      8:       return 32'h0000_008E;
      9:       return 32'h0000_0108;
      10:      return 32'h0000_0204;
      11:      return 32'h0000_0402;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_4001;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return (32'h1 << (w - 1)) | 32'h1;
    endcase
  endfunction

  function automatic logic [31:0] galois_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Galois LFSR that generates mole patterns; steps once per cycle with advance high.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter int unsigned       LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  localparam logic [31:0] Taps = lfsr_taps(LFSR_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= LFSR_W'(galois_step(32'(state), Taps));
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole sequencer: IDLE -> countdown -> timed play -> game over, with scoring
// of switch rising edges against lit moles and a session high score.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned       N_MOLES      = DEF_N_MOLES,
  parameter int unsigned       SCORE_W      = DEF_SCORE_W,
  parameter int unsigned       CD_SEC       = 5,
  parameter int unsigned       GAME_SEC     = 30,
  parameter int unsigned       LFSR_W       = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_W'(16'hACE1),
  parameter bit                MISS_PENALTY = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick_sec,
  input  logic               tick_step,
  input  logic [N_MOLES-1:0] switch_in,
  output logic [N_MOLES-1:0] led_out,
  output logic [1:0]         phase,
  output logic [7:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [SCORE_W-1:0] disp_value,
  output logic               new_high
);

  localparam int unsigned        SumW     = SCORE_W + 5;
  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [31:0]        Taps     = lfsr_taps(LFSR_W);
  localparam logic [7:0]         CdTime   = 8'(CD_SEC);
  localparam logic [7:0]         GameTime = 8'(GAME_SEC);

  phase_t             phase_q;
  logic [N_MOLES-1:0] led_q, sw_q;
  logic [7:0]         time_q;
  logic [SCORE_W-1:0] score_q, high_q, disp_q;
  logic               new_high_q;

  logic [LFSR_W-1:0]  lfsr_state;
  logic               lfsr_adv;
  logic [31:0]        lfsr_next;
  logic [N_MOLES-1:0] led_new;
  logic [N_MOLES-1:0] sw_edge, hit, miss;
  logic [4:0]         hit_cnt, miss_cnt;
  logic [SumW-1:0]    sum_hit;
  logic [SCORE_W-1:0] score_hit, score_play;
  logic               last_sec;
  logic               unused_lfsr;

  mole_lfsr #(
    .LFSR_W   (LFSR_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(lfsr_adv),
    .state  (lfsr_state)
  );

  assign last_sec = tick_sec && (time_q == 8'd1);
  assign lfsr_adv = ((phase_q == PH_PLAY) && tick_step) ||
                    ((phase_q == PH_COUNTDOWN) && last_sec);

  // The pattern loaded alongside an LFSR step is the post-step state, never all-dark.
  always_comb begin
    lfsr_next = galois_step(32'(lfsr_state), Taps);
    led_new   = lfsr_next[N_MOLES-1:0];
    if (led_new == '0) begin
      led_new = N_MOLES'(1);
    end
  end
  assign unused_lfsr = ^lfsr_next;

  assign sw_edge  = switch_in & ~sw_q;
  assign hit      = sw_edge & led_q;
  assign miss     = sw_edge & ~led_q;
  assign hit_cnt  = popcount16(16'(hit));
  assign miss_cnt = popcount16(16'(miss));

  // Hits saturate upward first, then the penalty saturates at zero.
  always_comb begin
    sum_hit    = SumW'(score_q) + SumW'(hit_cnt);
    score_hit  = (sum_hit > SumW'(ScoreMax)) ? ScoreMax : sum_hit[SCORE_W-1:0];
    score_play = score_hit;
    if (MISS_PENALTY) begin
      if (SumW'(miss_cnt) > SumW'(score_hit)) begin
        score_play = '0;
      end else begin
        score_play = score_hit - SCORE_W'(miss_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_IDLE;
      led_q      <= '0;
      sw_q       <= '0;
      time_q     <= '0;
      score_q    <= '0;
      high_q     <= '0;
      disp_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      sw_q       <= switch_in;
      new_high_q <= 1'b0;
      case (phase_q)
        PH_IDLE, PH_OVER: begin
          if (start) begin
            phase_q <= PH_COUNTDOWN;
            time_q  <= CdTime;
            disp_q  <= SCORE_W'(CdTime);
          end
        end
        PH_COUNTDOWN: begin
          if (last_sec) begin
            phase_q <= PH_PLAY;
            time_q  <= GameTime;
            score_q <= '0;
            led_q   <= led_new;
            disp_q  <= '0;
          end else if (tick_sec) begin
            time_q <= time_q - 8'd1;
            disp_q <= SCORE_W'(time_q - 8'd1);
          end
        end
        PH_PLAY: begin
          score_q <= score_play;
          disp_q  <= score_play;
          led_q   <= tick_step ? led_new : (led_q & ~hit);
          if (last_sec) begin
            phase_q <= PH_OVER;
            time_q  <= '0;
            led_q   <= '0;
            if (score_play > high_q) begin
              high_q     <= score_play;
              new_high_q <= 1'b1;
            end
          end else if (tick_sec) begin
            time_q <= time_q - 8'd1;
          end
        end
      endcase
    end
  end

  assign phase      = phase_q;
  assign led_out    = led_q;
  assign time_left  = time_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign disp_value = disp_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Scoreboarded directed bench: A = default build, B = 4-bit score with miss penalty.
module tb_whack_game_ctrl;

  typedef struct packed {
    logic [1:0]  ph;
    logic [4:0]  led;
    logic [7:0]  tl;
    logic [15:0] sc;
    logic [15:0] hs;
    logic [15:0] disp;
    logic        nh;
  } exp_t;

  localparam int I = 0, C = 1, P = 2, O = 3;

  logic clk;
  logic a_rst, a_start, a_tsec, a_tstep;
  logic b_rst, b_start, b_tsec, b_tstep;
  logic [4:0] a_sw, b_sw, a_led, b_led;
  logic [1:0] a_ph, b_ph;
  logic [7:0] a_tl, b_tl;
  logic [15:0] a_sc, a_hs, a_disp;
  logic [3:0] b_sc, b_hs, b_disp;
  logic a_nh, b_nh;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  whack_game_ctrl #(
    .N_MOLES(5), .SCORE_W(16), .CD_SEC(5), .GAME_SEC(30), .MISS_PENALTY(1'b0)
  ) dut_a (
    .clk(clk), .reset(a_rst), .start(a_start), .tick_sec(a_tsec), .tick_step(a_tstep),
    .switch_in(a_sw), .led_out(a_led), .phase(a_ph), .time_left(a_tl), .score(a_sc),
    .high_score(a_hs), .disp_value(a_disp), .new_high(a_nh)
  );

  whack_game_ctrl #(
    .N_MOLES(5), .SCORE_W(4), .CD_SEC(1), .GAME_SEC(20), .MISS_PENALTY(1'b1)
  ) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .tick_sec(b_tsec), .tick_step(b_tstep),
    .switch_in(b_sw), .led_out(b_led), .phase(b_ph), .time_left(b_tl), .score(b_sc),
    .high_score(b_hs), .disp_value(b_disp), .new_high(b_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int ph, int led, int tl, int sc, int hs, int nh);
    exp_t e;
    e.ph   = 2'(ph);
    e.led  = 5'(led);
    e.tl   = 8'(tl);
    e.sc   = 16'(sc);
    e.hs   = 16'(hs);
    e.nh   = 1'(nh);
    e.disp = (ph == I) ? 16'(hs) : (ph == C) ? 16'(tl) : 16'(sc);
    return e;
  endfunction

  // One clock of stimulus plus the outputs expected after the following rising edge.
  task automatic cyc(int sel, int st, int ts, int tp, int sw,
                     int ph, int led, int tl, int sc, int hs, int nh);
    @(negedge clk);
    if (sel == 0) begin
      a_start = 1'(st); a_tsec = 1'(ts); a_tstep = 1'(tp); a_sw = 5'(sw);
      q_a.push_back(mk(ph, led, tl, sc, hs, nh));
    end else begin
      b_start = 1'(st); b_tsec = 1'(ts); b_tstep = 1'(tp); b_sw = 5'(sw);
      q_b.push_back(mk(ph, led, tl, sc, hs, nh));
    end
  endtask

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_all(string who, exp_t e, logic [1:0] ph, logic [4:0] led,
                           logic [7:0] tl, logic [15:0] sc, logic [15:0] hs,
                           logic [15:0] disp, logic nh);
    chk({who, ".phase"}, 16'(ph), 16'(e.ph));
    chk({who, ".led_out"}, 16'(led), 16'(e.led));
    chk({who, ".time_left"}, 16'(tl), 16'(e.tl));
    chk({who, ".score"}, sc, e.sc);
    chk({who, ".high_score"}, hs, e.hs);
    chk({who, ".disp_value"}, disp, e.disp);
    chk({who, ".new_high"}, 16'(nh), 16'(e.nh));
  endtask

  // Monitor: compares whatever the stimulus queued, one step after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        check_all("A", q_a.pop_front(), a_ph, a_led, a_tl, a_sc, a_hs, a_disp, a_nh);
      end
      if (q_b.size() > 0) begin
        check_all("B", q_b.pop_front(), b_ph, b_led, b_tl, 16'(b_sc), 16'(b_hs),
                  16'(b_disp), b_nh);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b0; a_start = 1'b0; a_tsec = 1'b0; a_tstep = 1'b0; a_sw = '0;
    b_rst = 1'b0; b_start = 1'b0; b_tsec = 1'b0; b_tstep = 1'b0; b_sw = '0;
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // ---------------- DUT A ----------------
    cyc(0, 0, 0, 0, 0, I, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, C, 0, 5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, C, 0, 5, 0, 0, 0);              // start ignored in countdown
    for (int t = 4; t >= 1; t--) cyc(0, 0, 1, 0, 0, C, 0, t, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, P, 'h10, 30, 0, 0, 0);
    cyc(0, 0, 0, 0, 'b10001, P, 'h00, 30, 1, 0, 0);   // one hit, one unpenalised miss
    cyc(0, 0, 0, 1, 'b10001, P, 'h18, 30, 1, 0, 0);   // held switch scores nothing
    cyc(0, 1, 0, 0, 0, P, 'h18, 30, 1, 0, 0);         // start ignored in play
    cyc(0, 0, 0, 1, 'b01000, P, 'h1C, 30, 2, 0, 0);   // hit with step: new pattern unmasked
    cyc(0, 0, 0, 1, 'b01000, P, 'h0E, 30, 2, 0, 0);
    cyc(0, 0, 0, 0, 'b01110, P, 'b01000, 30, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, P, 'b01000, 30, 4, 0, 0);
    cyc(0, 0, 1, 0, 'b01000, P, 0, 29, 5, 0, 0);
    for (int t = 28; t >= 1; t--) cyc(0, 0, 1, 0, 'b01000, P, 0, t, 5, 0, 0);
    cyc(0, 0, 0, 1, 0, P, 'h07, 1, 5, 0, 0);
    cyc(0, 0, 1, 0, 'b00001, O, 0, 0, 6, 6, 1);        // hit on the final tick counts
    cyc(0, 0, 0, 0, 'b11111, O, 0, 0, 6, 6, 0);        // edges ignored in OVER
    cyc(0, 0, 0, 0, 0, O, 0, 0, 6, 6, 0);
    // second game, lower score
    cyc(0, 1, 0, 0, 0, C, 0, 5, 6, 6, 0);
    for (int t = 4; t >= 1; t--) cyc(0, 0, 1, 0, 0, C, 0, t, 6, 6, 0);
    cyc(0, 0, 1, 0, 0, P, 'h13, 30, 0, 6, 0);
    cyc(0, 0, 0, 0, 'b00001, P, 'b10010, 30, 1, 6, 0);
    for (int t = 29; t >= 1; t--) cyc(0, 0, 1, 0, 'b00001, P, 'b10010, t, 1, 6, 0);
    cyc(0, 0, 1, 0, 'b00001, O, 0, 0, 1, 6, 0);
    // third game, reset mid-play
    cyc(0, 1, 0, 0, 0, C, 0, 5, 1, 6, 0);
    for (int t = 4; t >= 1; t--) cyc(0, 0, 1, 0, 0, C, 0, t, 1, 6, 0);
    cyc(0, 0, 1, 0, 0, P, 'h09, 30, 0, 6, 0);
    cyc(0, 0, 0, 0, 'b01001, P, 0, 30, 2, 6, 0);
    @(negedge clk);
    a_rst = 1'b0;
    a_sw = '0;
    q_a.push_back(mk(I, 0, 0, 0, 0, 0));
    @(negedge clk);
    a_rst = 1'b1;
    cyc(0, 1, 0, 0, 0, C, 0, 5, 0, 0, 0);
    for (int t = 4; t >= 1; t--) cyc(0, 0, 1, 0, 0, C, 0, t, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, P, 'h10, 30, 0, 0, 0);          // LFSR reseeded by reset

    // ---------------- DUT B (SCORE_W=4, penalty) ----------------
    cyc(1, 0, 0, 0, 0, I, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, C, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, P, 'h10, 20, 0, 0, 0);
    cyc(1, 0, 0, 0, 'b00001, P, 'h10, 20, 0, 0, 0);   // miss at zero stays zero
    cyc(1, 0, 0, 0, 0, P, 'h10, 20, 0, 0, 0);
    cyc(1, 0, 0, 0, 'b10001, P, 0, 20, 0, 0, 0);      // hit applied before miss
    cyc(1, 0, 0, 1, 0, P, 'h18, 20, 0, 0, 0);
    cyc(1, 0, 0, 0, 'b11000, P, 0, 20, 2, 0, 0);
    cyc(1, 0, 0, 1, 0, P, 'h1C, 20, 2, 0, 0);
    cyc(1, 0, 0, 0, 'b11110, P, 0, 20, 4, 0, 0);      // +3 hits, -1 miss
    cyc(1, 0, 0, 1, 0, P, 'h0E, 20, 4, 0, 0);
    cyc(1, 0, 0, 0, 'b01110, P, 0, 20, 7, 0, 0);
    cyc(1, 0, 0, 1, 0, P, 'h07, 20, 7, 0, 0);
    cyc(1, 0, 0, 0, 'b00111, P, 0, 20, 10, 0, 0);
    cyc(1, 0, 0, 1, 0, P, 'h13, 20, 10, 0, 0);
    cyc(1, 0, 0, 0, 'b10011, P, 0, 20, 13, 0, 0);
    cyc(1, 0, 0, 1, 0, P, 'h09, 20, 13, 0, 0);
    cyc(1, 0, 0, 0, 'b01001, P, 0, 20, 15, 0, 0);
    cyc(1, 0, 0, 1, 0, P, 'h04, 20, 15, 0, 0);
    cyc(1, 0, 0, 0, 'b00100, P, 0, 20, 15, 0, 0);     // saturates at 15
    for (int t = 19; t >= 1; t--) cyc(1, 0, 1, 0, 'b00100, P, 0, t, 15, 0, 0);
    cyc(1, 0, 1, 0, 'b00100, O, 0, 0, 15, 15, 1);
    cyc(1, 0, 0, 0, 'b00100, O, 0, 0, 15, 15, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_a.size() + q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
